// File: rtl/conv_window_gen.sv
// Streaming 3x3 sliding-window generator: two line buffers plus a 3x3 shift
// register turn a raster pixel stream into packed windows for the conv unit.
module conv_window_gen #(
   parameter int unsigned N   = 8,
   parameter int unsigned IMG = 28,
   parameter int unsigned FIL = 3,
   parameter int unsigned CW  = $clog2(IMG)
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 start,
   input  logic                 in_valid,
   input  logic [N-1:0]         in_data,
   output logic                 in_ready,
   output logic                 out_valid,
   output logic [FIL*FIL*N-1:0] out_window,
   input  logic                 out_ready,
   output logic [CW-1:0]        out_row,
   output logic [CW-1:0]        out_col,
   output logic                 busy,
   output logic                 done
);

   localparam int unsigned WIN = FIL * FIL;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] RUN   = 2'd1;
   localparam logic [1:0] DRAIN = 2'd2;
   localparam logic [1:0] DONE  = 2'd3;

   localparam logic [CW-1:0] LAST = CW'(IMG - 1);
   localparam logic [CW-1:0] TWO  = CW'(2);

   logic [1:0]       state;
   logic [1:0]       state_nxt;
   logic [CW-1:0]    row;
   logic [CW-1:0]    col;
   logic [N-1:0]     lb0 [IMG];
   logic [N-1:0]     lb1 [IMG];
   logic [N-1:0]     win [WIN];
   logic [N-1:0]     win_nxt [WIN];
   logic [WIN*N-1:0] win_packed;
   logic             accept;
   logic             emit;
   logic             handshake;
   logic             last_px;

   // Backpressure: a new pixel only enters when the pending window can leave.
   assign in_ready  = (state == RUN) && (!out_valid || out_ready);
   assign busy      = (state == RUN) || (state == DRAIN);
   assign done      = (state == DONE);
   assign accept    = in_valid && in_ready;
   assign handshake = out_valid && out_ready;
   assign emit      = (row >= TWO) && (col >= TWO);
   assign last_px   = (row == LAST) && (col == LAST);

   always_ff @(posedge clock) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = RUN;
         RUN:     if (accept && last_px) state_nxt = DRAIN;
         DRAIN:   if (!out_valid || out_ready) state_nxt = DONE;
         default: state_nxt = IDLE;
      endcase
   end

   // Window shifts left; the new column is {two rows back, previous row, current pixel}.
   always_comb begin
      for (int k = 0; k < WIN; k++) win_nxt[k] = win[k];
      for (int i = 0; i < FIL; i++) begin
         for (int j = 0; j < FIL - 1; j++) win_nxt[i*FIL + j] = win[i*FIL + j + 1];
      end
      win_nxt[FIL-1]   = lb1[col];
      win_nxt[2*FIL-1] = lb0[col];
      win_nxt[3*FIL-1] = in_data;
      win_packed = '0;
      for (int k = 0; k < WIN; k++) win_packed[k*N +: N] = win_nxt[k];
   end

   // Line buffers and window taps need no reset: windows only appear after two full rows.
   always_ff @(posedge clock) begin
      if (accept) begin
         lb0[col] <= in_data;
         lb1[col] <= lb0[col];
         for (int k = 0; k < WIN; k++) win[k] <= win_nxt[k];
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         row        <= '0;
         col        <= '0;
         out_valid  <= 1'b0;
         out_row    <= '0;
         out_col    <= '0;
         out_window <= '0;
      end else begin
         if ((state == IDLE) && start) begin
            row <= '0;
            col <= '0;
         end else if (accept) begin
            if (col == LAST) begin
               col <= '0;
               row <= row + CW'(1);
            end else begin
               col <= col + CW'(1);
            end
         end

         if (accept && emit) begin
            out_valid  <= 1'b1;
            out_window <= win_packed;
            out_row    <= row - TWO;
            out_col    <= col - TWO;
         end else if (handshake) begin
            out_valid  <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_conv_window_gen.sv
// Self-checking bench for conv_window_gen: image-based reference model with a
// window scoreboard, table-driven frame runs and a mid-frame reset sequence.
module tb_conv_window_gen;

   localparam int unsigned N   = 8;
   localparam int unsigned IMG = 28;
   localparam int unsigned CW  = 5;
   localparam int unsigned WB  = 9 * N;
   localparam int          NWIN = (IMG - 2) * (IMG - 2);

   logic          clock = 1'b0;
   logic          reset;
   logic          start;
   logic          in_valid;
   logic [N-1:0]  in_data;
   logic          in_ready;
   logic          out_valid;
   logic [WB-1:0] out_window;
   logic          out_ready;
   logic [CW-1:0] out_row;
   logic [CW-1:0] out_col;
   logic          busy;
   logic          done;

   always #5 clock = ~clock;

   conv_window_gen dut (
      .clock      (clock),
      .reset      (reset),
      .start      (start),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_ready   (in_ready),
      .out_valid  (out_valid),
      .out_window (out_window),
      .out_ready  (out_ready),
      .out_row    (out_row),
      .out_col    (out_col),
      .busy       (busy),
      .done       (done)
   );

   typedef struct {
      logic [CW-1:0] row;
      logic [CW-1:0] col;
      logic [WB-1:0] win;
   } win_t;

   typedef struct {
      int vpct;
      int rpct;
      bit pat;
      int stall_win;
      bit inj;
      int exp_wins;
      int exp_dones;
   } frame_t;

   win_t         exp_q[$];
   win_t         spots[3];
   bit           spot_hit[3];
   frame_t       frames[3];
   logic [N-1:0] img [IMG][IMG];

   int checks = 0;
   int failures = 0;
   int px;
   int win_count;
   int done_count;
   bit last_hs;

   task automatic check(input string name, input logic [WB-1:0] act, input logic [WB-1:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
      end
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_out_valid"},  WB'(out_valid),  WB'(0));
      check({tag, "_in_ready"},   WB'(in_ready),   WB'(0));
      check({tag, "_busy"},       WB'(busy),       WB'(0));
      check({tag, "_done"},       WB'(done),       WB'(0));
      check({tag, "_out_row"},    WB'(out_row),    WB'(0));
      check({tag, "_out_col"},    WB'(out_col),    WB'(0));
      check({tag, "_out_window"}, out_window,      WB'(0));
   endtask

   // Sampled 1 time unit after the falling edge: decides what the next rising edge does.
   task automatic observe(input bit use_spots);
      bit   hs;
      bit   acc;
      int   r;
      int   c;
      win_t e;
      hs  = out_valid && out_ready;
      acc = in_valid && in_ready;
      check("valid_vs_model", WB'(out_valid), WB'(exp_q.size() != 0));
      if (last_hs) begin
         check("done_timing", WB'(done), WB'(1));
         last_hs = 1'b0;
      end
      if (done) done_count++;
      if (out_valid && !out_ready) check("bp_in_ready", WB'(in_ready), WB'(0));
      if (out_valid && exp_q.size() != 0) begin
         check("window", out_window, exp_q[0].win);
         check("row", WB'(out_row), WB'(exp_q[0].row));
         check("col", WB'(out_col), WB'(exp_q[0].col));
         check("col_le_25", WB'(out_col > CW'(25)), WB'(0));
         if (hs) begin
            if (use_spots) begin
               for (int k = 0; k < 3; k++) begin
                  if (out_row == spots[k].row && out_col == spots[k].col) begin
                     check("spot_window", out_window, spots[k].win);
                     spot_hit[k] = 1'b1;
                  end
               end
            end
            void'(exp_q.pop_front());
            win_count++;
            if (win_count == NWIN) last_hs = 1'b1;
         end
      end
      if (acc) begin
         r = px / IMG;
         c = px % IMG;
         if (px < IMG * IMG) begin
            img[r][c] = in_data;
            if (r >= 2 && c >= 2) begin
               e.row = CW'(r - 2);
               e.col = CW'(c - 2);
               e.win = '0;
               for (int i = 0; i < 3; i++)
                  for (int j = 0; j < 3; j++)
                     e.win[(3*i + j)*N +: N] = img[r-2+i][c-2+j];
               exp_q.push_back(e);
            end
         end
         px++;
      end
   endtask

   task automatic drive(input logic v, input logic [N-1:0] d, input logic rdy,
                        input logic st, input bit use_spots);
      @(negedge clock);
      in_valid  = v;
      in_data   = d;
      out_ready = rdy;
      start     = st;
      #1;
      observe(use_spots);
   endtask

   task automatic run_frame(input frame_t f, input int abort_at);
      int           cyc;
      int           stall;
      int           r;
      int           c;
      bit           inj_run;
      bit           inj_drain;
      logic         v;
      logic         rdy;
      logic         st;
      logic [N-1:0] d;
      cyc = 0; stall = 0; inj_run = 1'b0; inj_drain = 1'b0;
      px = 0; win_count = 0; done_count = 0; last_hs = 1'b0;
      exp_q.delete();
      for (int k = 0; k < 3; k++) spot_hit[k] = 1'b0;
      drive(1'b0, '0, 1'b1, 1'b1, f.pat);
      while (done_count == 0 && cyc < 20000) begin
         if (abort_at >= 0 && px >= abort_at) return;
         v   = (int'($urandom_range(99)) < f.vpct);
         rdy = (int'($urandom_range(99)) < f.rpct);
         st  = 1'b0;
         if (f.stall_win >= 0 && win_count == f.stall_win && out_valid && stall < 5) begin
            rdy = 1'b0;
            v   = 1'b1;
            stall++;
         end
         if (f.inj && !inj_run && px == 400) begin
            st = 1'b1;
            inj_run = 1'b1;
         end
         if (f.inj && !inj_drain && px == IMG * IMG) begin
            st = 1'b1;
            inj_drain = 1'b1;
         end
         r = px / IMG;
         c = px % IMG;
         d = f.pat ? N'((28*r + c) & 255) : N'($urandom);
         drive(v, d, rdy, st, f.pat);
         cyc++;
      end
      drive(1'b0, '0, 1'b1, 1'b0, f.pat);
      drive(1'b0, '0, 1'b1, 1'b0, f.pat);
      check("idle_done_low", WB'(done), WB'(0));
      check("idle_busy", WB'(busy), WB'(0));
      check("idle_in_ready", WB'(in_ready), WB'(0));
      check("window_count", WB'(win_count), WB'(f.exp_wins));
      check("done_count", WB'(done_count), WB'(f.exp_dones));
      check("queue_empty", WB'(exp_q.size()), WB'(0));
      if (f.pat) begin
         for (int k = 0; k < 3; k++) check("spot_seen", WB'(spot_hit[k]), WB'(1));
      end
   endtask

   initial begin
      frame_t second;
      frame_t aborted;

      spots[0] = '{row: CW'(0),  col: CW'(0),
                   win: {8'd58, 8'd57, 8'd56, 8'd30, 8'd29, 8'd28, 8'd2, 8'd1, 8'd0}};
      spots[1] = '{row: CW'(25), col: CW'(25),
                   win: {8'd15, 8'd14, 8'd13, 8'd243, 8'd242, 8'd241, 8'd215, 8'd214, 8'd213}};
      spots[2] = '{row: CW'(10), col: CW'(5),
                   win: {8'd87, 8'd86, 8'd85, 8'd59, 8'd58, 8'd57, 8'd31, 8'd30, 8'd29}};

      frames[0] = '{vpct: 100, rpct: 100, pat: 1'b1, stall_win: -1,  inj: 1'b0, exp_wins: NWIN, exp_dones: 1};
      frames[1] = '{vpct: 100, rpct: 100, pat: 1'b1, stall_win: 100, inj: 1'b1, exp_wins: NWIN, exp_dones: 1};
      frames[2] = '{vpct: 50,  rpct: 50,  pat: 1'b0, stall_win: -1,  inj: 1'b0, exp_wins: NWIN, exp_dones: 1};
      aborted   = '{vpct: 50,  rpct: 50,  pat: 1'b0, stall_win: -1,  inj: 1'b0, exp_wins: 0,    exp_dones: 0};
      second    = '{vpct: 70,  rpct: 70,  pat: 1'b1, stall_win: -1,  inj: 1'b0, exp_wins: NWIN, exp_dones: 1};

      reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      repeat (3) @(negedge clock);
      #1;
      check_reset_values("rst");
      reset = 1'b0;

      for (int i = 0; i < 3; i++) run_frame(frames[i], -1);

      // Mid-frame reset after 300 pixels, then a clean frame must follow.
      run_frame(aborted, 300);
      @(negedge clock);
      reset = 1'b1; in_valid = 1'b1; out_ready = 1'b0; start = 1'b0;
      @(negedge clock);
      #1;
      check_reset_values("abort");
      reset = 1'b0; in_valid = 1'b0;
      exp_q.delete();
      run_frame(second, -1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/conv_window_gen.md
Name: conv_window_gen

Overview:
Streaming sliding-window generator that sits directly upstream of the convolution unit in the CNN co-processor datapath. It accepts one raster-order image pixel per handshake for an IMG x IMG frame. It buffers two previous image rows in line buffers. For every valid position it emits a packed 3x3 window (9*N bits), which is the conv unit's image operand.

Parameters:
N, 8, pixel data width in bits.
IMG, 28, image width and height in pixels (square frame).
FIL, 3, window size; only 3 is supported, and the output packing is fixed at 9 elements.
CW, $clog2(IMG) (5 at default), width of the row/column coordinate ports.

Ports:
clock  input  1  system clock; all state updates on the rising edge.
reset  input  1  synchronous, active-high reset.
start  input  1  one-cycle pulse; begins a frame when in IDLE; ignored in every other state.
in_valid  input  1  in_data is valid.
in_data  input  N  pixel, raster order (row-major, top-left first).
in_ready  output  1  block accepts a pixel this cycle.
out_valid  output  1  out_window holds a valid window.
out_window  output  9*N  3x3 window; element (i,j) is at bits [(3*i+j)*N +: N]; i=0 is the top (oldest) row; j=0 is the leftmost column.
out_ready  input  1  downstream consumes the window when it is high and out_valid is high.
out_row  output  CW  row of the window's top-left pixel.
out_col  output  CW  column of the window's top-left pixel.
busy  output  1  high in RUN and DRAIN.
done  output  1  one-cycle pulse after the frame's final window is consumed.

Behaviour:
- Reset (synchronous) values:
  - state=IDLE.
  - out_valid=0, in_ready=0, busy=0, done=0.
  - out_row=0, out_col=0, out_window=0.
  - Pixel row/col counters=0.
  - Line-buffer contents are not cleared; they need no clearing because windows are only emitted once both buffered rows have been refilled.
- States:
  - IDLE: in_ready=0. start -> RUN, with counters zeroed.
  - RUN: in_ready = !out_valid || out_ready. Acceptance of pixel (IMG-1, IMG-1) -> DRAIN.
  - DRAIN: in_ready=0. When no window is left pending (out_valid=0, or the handshake completes this cycle) -> DONE.
  - DONE: done=1 for exactly one cycle -> IDLE.
- Pixel acceptance (in_valid && in_ready) at position (r,c):
  - Line buffer 0 (the previous row) and line buffer 1 (two rows back) each hold IMG entries, indexed by c. Each column update shifts in_data -> lb0[c] -> lb1[c].
  - The 3x3 shift register shifts left, and new column {lb1[c], lb0[c], in_data} enters at j=2.
  - c increments. When c=IMG-1, c wraps to 0 and r increments. There is no separate wrap state.
- Window emission:
  - A window is emitted if and only if the accepted pixel has r>=2 and c>=2.
  - On the next rising edge: out_valid=1, out_window=updated 3x3, out_row=r-2, out_col=c-2.
  - Latency is 1 cycle from acceptance to out_valid.
  - Pixels with c<2 never emit, so no window straddles a row boundary.
  - Windows per frame = (IMG-2)^2 = 676 at default.
- Output hold:
  - While out_valid && !out_ready, out_window, out_row and out_col are stable and in_ready=0 (backpressure).
  - A handshake with no new emitting acceptance in the same cycle clears out_valid.
  - A handshake together with a new emitting acceptance keeps out_valid=1 and loads the new window.
- in_valid gaps: no state change and no output change other than the handshake clear.
- Reset mid-frame: immediate return to IDLE with all outputs at reset values. The next start begins a clean frame.
- Arithmetic: counters are CW-bit unsigned. Data passes through unmodified; no arithmetic on pixels.

Test Plan:
- Full frame, in_valid=1, out_ready=1, pixel value=(28r+c) mod 256:
  - Exactly 676 windows; first out_valid is the cycle after pixel index 58 is accepted.
  - First window: out_row=0, out_col=0, bytes LSB-first = 0,1,2,28,29,30,56,57,58.
  - Last window: (25,25), bytes 213,214,215,241,242,243,13,14,15.
  - done pulses one cycle later, then the block returns to IDLE.
- Backpressure: hold out_ready=0 for 5 cycles while a window is pending.
  - in_ready=0 throughout, and window, row and col are unchanged.
  - After release, no window is lost or duplicated; total stays 676.
- Random in_valid (50%) with random out_ready (50%):
  - The window sequence matches the reference model in order and content.
- Reset asserted at pixel 300, then a new start and full frame:
  - Outputs go to reset values on the next edge.
  - The second frame yields 676 correct windows, with no stale data in the first window.
- start pulsed during RUN and during DRAIN: ignored; counters are unaffected and done pulses once.
- Row-boundary check: pixels at c=0 and c=1 of every row produce no out_valid; out_col never exceeds 25.
